// File: rtl/song_sequencer.sv
// Order-list sequencer feeding note_sequencer: walks an order ROM, loads patterns, follows jumps, stops at END.
// Optional feature: define SONG_SEQ_LOOP_EN to honour jump entries (otherwise a jump entry ends the song).
module song_sequencer #(
  parameter int ORDER_AW = 5,
  parameter int ADDR_W   = 5,
  parameter int LEN_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_note_valid,
  output logic [ORDER_AW-1:0] o_order_addr,
  input  logic [15:0]         i_order_data,
  output logic [ADDR_W-1:0]   o_new_addr,
  output logic [LEN_W-1:0]    o_new_pattern_len,
  output logic                o_new_addr_valid,
  output logic                o_playing,
  output logic                o_song_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_PLAY
  } state_t;

  state_t              state_q, state_d;
  logic [ORDER_AW-1:0] order_idx_q, order_idx_d;
  logic [ORDER_AW-1:0] order_addr_q, order_addr_d;
  logic [ADDR_W-1:0]   new_addr_q, new_addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    note_cnt_q, note_cnt_d;
  logic                valid_q, valid_d;
  logic                playing_q, playing_d;
  logic                song_end_q, song_end_d;
`ifdef SONG_SEQ_LOOP_EN
  logic                jump_cnt_q, jump_cnt_d;
  logic [ORDER_AW-1:0] entry_target;
`endif

  logic              entry_jump;
  logic              entry_end;
  logic [LEN_W-1:0]  entry_len;
  logic [ADDR_W-1:0] entry_addr;
  logic              unused_data;

  assign entry_jump  = i_order_data[15];
  assign entry_end   = !i_order_data[15] && (i_order_data[9:5] == 5'd0);
  assign entry_len   = LEN_W'(i_order_data[9:5]);
  assign entry_addr  = ADDR_W'(i_order_data[4:0]);
  assign unused_data = ^i_order_data[14:10];
`ifdef SONG_SEQ_LOOP_EN
  assign entry_target = i_order_data[ORDER_AW-1:0];
`endif

  always_comb begin
    state_d      = state_q;
    order_idx_d  = order_idx_q;
    order_addr_d = order_addr_q;
    new_addr_d   = new_addr_q;
    len_d        = len_q;
    note_cnt_d   = note_cnt_q;
    valid_d      = 1'b0;
    song_end_d   = 1'b0;
`ifdef SONG_SEQ_LOOP_EN
    jump_cnt_d   = jump_cnt_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        order_addr_d = order_idx_q;
        state_d      = S_WAIT;
      end
      S_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        if (entry_jump) begin
`ifdef SONG_SEQ_LOOP_EN
          // A second jump with no pattern played in between would spin forever.
          if (jump_cnt_q) begin
            song_end_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            order_idx_d = entry_target;
            jump_cnt_d  = 1'b1;
            state_d     = S_FETCH;
          end
`else
          song_end_d = 1'b1;
          state_d    = S_IDLE;
`endif
        end else if (entry_end) begin
          song_end_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          new_addr_d = entry_addr;
          len_d      = entry_len;
          valid_d    = 1'b1;
          note_cnt_d = '0;
`ifdef SONG_SEQ_LOOP_EN
          jump_cnt_d = 1'b0;
`endif
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        // The note reported alongside the load strobe belongs to the previous pattern.
        if (i_note_valid && !valid_q) begin
          note_cnt_d = note_cnt_q + LEN_W'(1);
          if (note_cnt_q == len_q - LEN_W'(1)) begin
            order_idx_d = order_idx_q + ORDER_AW'(1);
            state_d     = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_stop) begin
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      song_end_d = 1'b0;
    end else if (i_start) begin
      state_d     = S_FETCH;
      order_idx_d = '0;
      note_cnt_d  = '0;
      valid_d     = 1'b0;
      song_end_d  = 1'b0;
`ifdef SONG_SEQ_LOOP_EN
      jump_cnt_d  = 1'b0;
`endif
    end

    playing_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      order_idx_q  <= '0;
      order_addr_q <= '0;
      new_addr_q   <= '0;
      len_q        <= '0;
      note_cnt_q   <= '0;
      valid_q      <= 1'b0;
      playing_q    <= 1'b0;
      song_end_q   <= 1'b0;
`ifdef SONG_SEQ_LOOP_EN
      jump_cnt_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      order_idx_q  <= order_idx_d;
      order_addr_q <= order_addr_d;
      new_addr_q   <= new_addr_d;
      len_q        <= len_d;
      note_cnt_q   <= note_cnt_d;
      valid_q      <= valid_d;
      playing_q    <= playing_d;
      song_end_q   <= song_end_d;
`ifdef SONG_SEQ_LOOP_EN
      jump_cnt_q   <= jump_cnt_d;
`endif
    end
  end

  assign o_order_addr      = order_addr_q;
  assign o_new_addr        = new_addr_q;
  assign o_new_pattern_len = len_q;
  assign o_new_addr_valid  = valid_q;
  assign o_playing         = playing_q;
  assign o_song_end        = song_end_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer; expectations follow SONG_SEQ_LOOP_EN when it is defined.
module tb_song_sequencer;

  localparam int ORDER_AW = 5;
  localparam int ADDR_W   = 5;
  localparam int LEN_W    = 5;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b1;
  logic                i_start = 1'b0;
  logic                i_stop = 1'b0;
  logic                i_note_valid = 1'b0;
  logic [ORDER_AW-1:0] o_order_addr;
  logic [15:0]         i_order_data = 16'h0000;
  logic [ADDR_W-1:0]   o_new_addr;
  logic [LEN_W-1:0]    o_new_pattern_len;
  logic                o_new_addr_valid;
  logic                o_playing;
  logic                o_song_end;

  logic [15:0] rom [32];
  int errors = 0;
  int checks = 0;
  int loadCount = 0;
  int endCount = 0;

  song_sequencer #(
    .ORDER_AW(ORDER_AW),
    .ADDR_W(ADDR_W),
    .LEN_W(LEN_W)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_stop(i_stop),
    .i_note_valid(i_note_valid),
    .o_order_addr(o_order_addr),
    .i_order_data(i_order_data),
    .o_new_addr(o_new_addr),
    .o_new_pattern_len(o_new_pattern_len),
    .o_new_addr_valid(o_new_addr_valid),
    .o_playing(o_playing),
    .o_song_end(o_song_end)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous order ROM: data appears one cycle after the address.
  always @(posedge i_clk) i_order_data <= rom[o_order_addr];

  // Count strobes on the falling edge so silent windows can be checked afterwards.
  always @(negedge i_clk) begin
    if (o_new_addr_valid) loadCount++;
    if (o_song_end) endCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs for exactly one clock edge, then sample 1ns after it.
  task automatic applyStimulus(input logic start, input logic stop, input logic note);
    i_start = start;
    i_stop = stop;
    i_note_valid = note;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_stop = 1'b0;
    i_note_valid = 1'b0;
  endtask

  // n = cycles since the last driven edge until the strobe is seen, or -1 on timeout.
  task automatic waitLoad(input int budget, output int n);
    n = 1;
    while (!o_new_addr_valid && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!o_new_addr_valid) n = -1;
  endtask

  task automatic waitEnd(input int budget, output int n);
    n = 1;
    while (!o_song_end && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!o_song_end) n = -1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_order_addr"}, 32'(o_order_addr), 0);
    checkOutput({tag, "_addr"}, 32'(o_new_addr), 0);
    checkOutput({tag, "_len"}, 32'(o_new_pattern_len), 0);
    checkOutput({tag, "_valid"}, 32'(o_new_addr_valid), 0);
    checkOutput({tag, "_playing"}, 32'(o_playing), 0);
    checkOutput({tag, "_song_end"}, 32'(o_song_end), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int l0;
    int e0;
    clearRom();

    // Reset values, observed asynchronously before any clock edge.
    #2 i_rst_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Single pattern followed by END: start latency, outputs, end latency.
    rom[0] = 16'h0064;
    rom[1] = 16'h0000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_play_rise", 32'(o_playing), 1);
    checkOutput("t1_no_load_fetch", 32'(o_new_addr_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_no_load_decode", 32'(o_new_addr_valid), 0);
    checkOutput("t1_order_addr0", 32'(o_order_addr), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_load_n4", 32'(o_new_addr_valid), 1);
    checkOutput("t1_addr", 32'(o_new_addr), 4);
    checkOutput("t1_len", 32'(o_new_pattern_len), 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_strobe_one_cycle", 32'(o_new_addr_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_still_playing", 32'(o_playing), 1);
    waitEnd(12, n);
    checkOutput("t1_end_latency", 32'(n), 4);
    checkOutput("t1_play_fall", 32'(o_playing), 0);
    checkOutput("t1_addr_held", 32'(o_new_addr), 4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_end_one_cycle", 32'(o_song_end), 0);

    // A note arriving in the strobe cycle must not be counted.
    rom[0] = 16'h0047;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    checkOutput("t2_load_latency", 32'(n), 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    e0 = endCount;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t2_strobe_note_ignored", 32'(endCount - e0), 0);
    checkOutput("t2_playing", 32'(o_playing), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitEnd(12, n);
    checkOutput("t2_end_latency", 32'(n), 4);

    // Two patterns and a jump back to order 0.
    rom[0] = 16'h0041;
    rom[1] = 16'h0029;
    rom[2] = 16'h8000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    checkOutput("t3_first_lat", 32'(n), 4);
    checkOutput("t3_first_addr", 32'(o_new_addr), 1);
    checkOutput("t3_first_len", 32'(o_new_pattern_len), 2);
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitLoad(12, n);
      checkOutput($sformatf("t3_to9_lat%0d", rep), 32'(n), 4);
      checkOutput($sformatf("t3_to9_addr%0d", rep), 32'(o_new_addr), 9);
      checkOutput($sformatf("t3_to9_len%0d", rep), 32'(o_new_pattern_len), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef SONG_SEQ_LOOP_EN
      waitLoad(16, n);
      checkOutput($sformatf("t3_loop_lat%0d", rep), 32'(n), 7);
      checkOutput($sformatf("t3_loop_addr%0d", rep), 32'(o_new_addr), 1);
      checkOutput($sformatf("t3_loop_len%0d", rep), 32'(o_new_pattern_len), 2);
`else
      waitEnd(12, n);
      checkOutput("t3_jump_is_end", 32'(n), 4);
      checkOutput("t3_idle_after_end", 32'(o_playing), 0);
      break;
`endif
    end
`ifdef SONG_SEQ_LOOP_EN
    // Restart while playing order 1 goes back to order 0.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitLoad(12, n);
    checkOutput("t3_pre_restart_addr", 32'(o_new_addr), 9);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    checkOutput("t3_restart_lat", 32'(n), 4);
    checkOutput("t3_restart_addr", 32'(o_new_addr), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_stopped", 32'(o_playing), 0);
`endif

    // Two jumps in a row with no pattern played.
    clearRom();
    rom[0] = 16'h8001;
    rom[1] = 16'h8000;
    l0 = loadCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEnd(16, n);
`ifdef SONG_SEQ_LOOP_EN
    checkOutput("t4_double_jump_end", 32'(n), 7);
`else
    checkOutput("t4_jump_end", 32'(n), 4);
`endif
    checkOutput("t4_no_loads", 32'(loadCount - l0), 0);
    checkOutput("t4_idle", 32'(o_playing), 0);

    // Stop coinciding with the last note, stop beating start, stop in DECODE.
    rom[0] = 16'h0023;
    rom[1] = 16'h0025;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    checkOutput("t5_load_addr", 32'(o_new_addr), 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    l0 = loadCount;
    e0 = endCount;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t5_stop_idle", 32'(o_playing), 0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_stop_no_load", 32'(loadCount - l0), 0);
    checkOutput("t5_stop_no_end", 32'(endCount - e0), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    l0 = loadCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t5_stop_beats_start", 32'(o_playing), 0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_stop_beats_start_noload", 32'(loadCount - l0), 0);
    l0 = loadCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_decode_stop_valid", 32'(o_new_addr_valid), 0);
    checkOutput("t5_decode_stop_idle", 32'(o_playing), 0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_decode_stop_noload", 32'(loadCount - l0), 0);

    // Every entry a one-note pattern: the order index wraps 31 -> 0.
    for (int i = 0; i < 32; i++) rom[i] = 16'h0020 | 16'(i);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 34; k++) begin
      waitLoad(12, n);
      checkOutput($sformatf("t6_lat%0d", k), 32'(n), 4);
      checkOutput($sformatf("t6_addr%0d", k), 32'(o_new_addr), 32'(k % 32));
      checkOutput($sformatf("t6_order%0d", k), 32'(o_order_addr), 32'(k % 32));
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a pattern.
    clearRom();
    rom[0] = 16'h0064;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #3 i_rst_n = 1'b0;
    #1 checkAllZero("t7_async");
    @(negedge i_clk) i_rst_n = 1'b1;
    l0 = loadCount;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t7_idle_after_reset", 32'(o_playing), 0);
    checkOutput("t7_no_load_after_reset", 32'(loadCount - l0), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitLoad(12, n);
    checkOutput("t7_resume_lat", 32'(n), 4);
    checkOutput("t7_resume_addr", 32'(o_new_addr), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
